// File: rtl/ads1672_evm_if.sv
// Serial/control bus between the ADS1672 EVM controller and the ADC.
// The master side is the controller; the slave side is the converter.
interface ads1672_evm_if;
    logic fsx;
    logic start;
    logic fsr;
    logic drr;
    logic drdy_n;
    logic clkx;
    logic clkr;

    modport master (
        output fsx, start,
        input  fsr, drr, drdy_n, clkx, clkr
    );

    modport slave (
        input  fsx, start,
        output fsr, drr, drdy_n, clkx, clkr
    );
endinterface

// File: rtl/ads1672_evm.sv
// ADS1672 conversion controller: raises START, waits for DRDY, frames a
// serial readout with FSX and captures a DATA_WIDTH-bit word MSB first.
module ads1672_evm #(
    parameter int DATA_WIDTH   = 24,
    parameter int DRDY_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  measure,
    ads1672_evm_if.master         adc,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int TMO_W = $clog2(DRDY_TIMEOUT + 1);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRDY_TIMEOUT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        FRAME,
        SHIFT,
        LOAD
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              drdy_sync;
    logic [1:0]              drr_sync;
    logic                    drdy_s;
    logic                    drr_s;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    start_q;
    logic                    fsx_q;

    // Return clocks and frame-sync return carry no information we act on.
    logic unused_adc;
    assign unused_adc = ^{adc.fsr, adc.clkx, adc.clkr};

    // drdy_n idles high, so its synchronizer resets to 1 to avoid a false ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drdy_sync <= 2'b11;
            drr_sync  <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the old value of the previous stage.
            drdy_sync <= {drdy_sync[0], adc.drdy_n};
            drr_sync  <= {drr_sync[0], adc.drr};
        end
    end

    assign drdy_s = drdy_sync[1];
    assign drr_s  = drr_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        start_q    = 1'b0;
        fsx_q      = 1'b0;
        case (state)
            IDLE: begin
                if (measure) begin
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                start_q = 1'b1;
                if (!drdy_s) begin
                    state_next = FRAME;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = IDLE;
                end
            end
            FRAME: begin
                start_q    = 1'b1;
                fsx_q      = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                start_q = 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign adc.start = start_q;
    assign adc.fsx   = fsx_q;

    // Counters clear outside their own state, so FRAME always hands SHIFT a zero bit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: shreg and data_out are plain registers, not a memory, so resetting them is cheap and required.
            tmo_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            data_out <= '0;
        end else begin
            tmo_cnt <= (state == CONVERT) ? tmo_cnt + TMO_W'(1) : '0;
            bit_cnt <= (state == SHIFT) ? bit_cnt + BIT_W'(1) : '0;
            if (state == SHIFT) begin
                shreg <= {shreg[DATA_WIDTH-2:0], drr_s};
            end
            if (state == LOAD) begin
                data_out <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_ads1672_evm.sv
// Self-checking bench for ads1672_evm: table of conversions, random
// conversions against a timing model, and reset/abort sequences.
module tb_ads1672_evm;

    localparam int DW  = 24;
    localparam int TMO = 1024;

    logic          clk;
    logic          rst;
    logic          measure;
    logic          drr;
    logic          drdy_n;
    logic          fsr_noise;
    logic [DW-1:0] data_out;

    int n_cmp;
    int n_err;

    logic [DW-1:0] model_data;

    ads1672_evm_if bus ();

    assign bus.drr    = drr;
    assign bus.drdy_n = drdy_n;
    assign bus.fsr    = fsr_noise;
    assign bus.clkx   = clk;
    assign bus.clkr   = ~clk;

    ads1672_evm #(
        .DATA_WIDTH  (DW),
        .DRDY_TIMEOUT(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .measure (measure),
        .adc     (bus),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not reach its summary, got timeout, wanted finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [DW-1:0] word;
        int            d;        // cycles from measure to drdy_n low; <0 means never
        bit            extra;    // second measure pulse during SHIFT
        bit            toggle;   // wiggle drdy_n during the readout
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    // One conversion. Index i counts falling edges after the edge that sampled measure.
    // Model: drdy seen 2 cycles late -> fsx at d+2; start high d+DW+3 cycles;
    // data_out changes DW+2 cycles after fsx; a timeout holds start TMO cycles.
    task automatic run_conv(input logic [DW-1:0] word, input int d, input bit extra,
                            input bit toggle, input logic [DW-1:0] exp_final, input string tag);
        int n_cyc, load_idx, s_first, s_total, f_first, f_count, bad_idx;
        logic [DW-1:0] exp_d;
        n_cyc    = (d < 0) ? TMO + 10 : d + DW + 12;
        load_idx = (d < 0) ? n_cyc + 1 : d + DW + 4;
        s_first  = -1;
        s_total  = 0;
        f_first  = -1;
        f_count  = 0;
        bad_idx  = -1;
        @(negedge clk);
        measure = 1'b1;
        @(negedge clk);
        measure = 1'b0;
        for (int i = 0; i < n_cyc; i++) begin
            if (bus.start === 1'b1) begin
                if (s_first < 0) s_first = i;
                s_total++;
            end
            if (bus.fsx === 1'b1) begin
                if (f_first < 0) f_first = i;
                f_count++;
            end
            exp_d = (i >= load_idx) ? word : model_data;
            if (data_out !== exp_d && bad_idx < 0) bad_idx = i;

            drr       = 1'($urandom_range(0, 1));
            fsr_noise = 1'($urandom_range(0, 1));
            measure   = (extra && d >= 0 && i == d + 10) ? 1'b1 : 1'b0;
            if (d >= 0) begin
                if (i == d - 1) drdy_n = 1'b0;
                if (i >= d + 1 && i < d + 1 + DW) drr = word[DW - 1 - (i - d - 1)];
                if (toggle && i >= d + 3 && i < d + 1 + DW) drdy_n = 1'($urandom_range(0, 1));
                if (i == d + 1 + DW) drdy_n = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, " start_first"}, 64'(s_first), 64'(0));
        check({tag, " start_cycles"}, 64'(s_total), 64'((d < 0) ? TMO : d + DW + 3));
        check({tag, " fsx_pulses"}, 64'(f_count), 64'((d < 0) ? 0 : 1));
        check({tag, " fsx_cycle"}, 64'(f_first), 64'((d < 0) ? -1 : d + 2));
        check({tag, " data_timing_bad_cycle"}, 64'(bad_idx), 64'(-1));
        check({tag, " data_final"}, 64'(data_out), 64'(exp_final));
        model_data = (d < 0) ? model_data : word;
    endtask

    initial begin
        logic [DW-1:0] w;
        n_cmp      = 0;
        n_err      = 0;
        model_data = '0;
        rst        = 1'b1;
        measure    = 1'b0;
        drr        = 1'b0;
        drdy_n     = 1'b1;
        fsr_noise  = 1'b0;

        vecs[0] = '{24'hA5C3F0,  5, 1'b0, 1'b0, 24'hA5C3F0};
        vecs[1] = '{24'h123456, -1, 1'b0, 1'b0, 24'hA5C3F0};
        vecs[2] = '{24'h5A5A5A,  7, 1'b1, 1'b1, 24'h5A5A5A};
        vecs[3] = '{24'hFFFFFF,  3, 1'b0, 1'b0, 24'hFFFFFF};
        vecs[4] = '{24'h000001,  1, 1'b0, 1'b1, 24'h000001};

        // Power-on reset held for two cycles.
        repeat (2) @(negedge clk);
        check("reset start", 64'(bus.start), 64'(0));
        check("reset fsx", 64'(bus.fsx), 64'(0));
        check("reset data_out", 64'(data_out), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle start", 64'(bus.start), 64'(0));

        for (int v = 0; v < 5; v++) begin
            run_conv(vecs[v].word, vecs[v].d, vecs[v].extra, vecs[v].toggle,
                     vecs[v].exp_data, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 20; r++) begin
            w = DW'($urandom);
            run_conv(w, int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), w, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a readout (around bit 12).
        w = 24'hC0FFEE;
        @(negedge clk);
        measure = 1'b1;
        @(negedge clk);
        measure = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) drdy_n = 1'b0;
            if (i >= 6) drr = w[DW - 1 - (i - 6)];
            @(negedge clk);
        end
        check("midshift start before rst", 64'(bus.start), 64'(1));
        rst     = 1'b1;
        measure = 1'b1;
        #1;
        check("abort data_out", 64'(data_out), 64'(0));
        check("abort start", 64'(bus.start), 64'(0));
        check("abort fsx", 64'(bus.fsx), 64'(0));
        @(negedge clk);
        drdy_n = 1'b1;
        @(negedge clk);
        check("abort held data_out", 64'(data_out), 64'(0));
        check("abort held start", 64'(bus.start), 64'(0));
        rst     = 1'b0;
        measure = 1'b0;
        @(negedge clk);
        check("no start from measure during rst", 64'(bus.start), 64'(0));
        repeat (3) @(negedge clk);
        model_data = '0;
        run_conv(24'h3C3C3C, 4, 1'b0, 1'b0, 24'h3C3C3C, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
